// File: rtl/codec_init_sequencer.sv
// codec_init_sequencer: walks the fixed audio-codec register table through the IIC write controller,
// retrying NACKed or timed-out writes and reporting done or error.
module codec_init_sequencer #(
    parameter int POWERUP_DELAY = 16,
    parameter int GAP_CYCLES    = 4,
    parameter int MAX_RETRY     = 3,
    parameter int TIMEOUT       = 63
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Iic_End,
    input  logic        Iic_Ack,
    output logic [23:0] IIC_data,
    output logic        Go,
    output logic [3:0]  Index,
    output logic        Config_Done,
    output logic        Config_Err
);
    localparam int PD   = POWERUP_DELAY < 1 ? 1 : POWERUP_DELAY;
    localparam int GC   = GAP_CYCLES < 3 ? 3 : GAP_CYCLES;
    localparam int M1   = PD > GC ? PD : GC;
    localparam int CMAX = M1 > TIMEOUT ? M1 : TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int RW   = $clog2(MAX_RETRY + 2);

    localparam logic [2:0] S_DELAY = 3'd0;
    localparam logic [2:0] S_GAP   = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERROR = 3'd5;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [RW-1:0] retry;
    logic [23:0]   word;
    logic          ok;
    logic          fail;

    always_comb begin
        case (Index)
            4'd0:    word = 24'h341E00;
            4'd1:    word = 24'h340017;
            4'd2:    word = 24'h340217;
            4'd3:    word = 24'h340479;
            4'd4:    word = 24'h340679;
            4'd5:    word = 24'h340812;
            4'd6:    word = 24'h340A00;
            4'd7:    word = 24'h340C00;
            4'd8:    word = 24'h340E01;
            4'd9:    word = 24'h341000;
            4'd10:   word = 24'h341201;
            default: word = 24'h341E00;
        endcase
    end

    // A timeout in RUN is handled exactly like a NACK seen in CHECK.
    always_comb begin
        ok   = state == S_CHECK && !Iic_Ack;
        fail = (state == S_CHECK && Iic_Ack) ||
               (state == S_RUN && !Iic_End && cnt == CW'(TIMEOUT - 1));
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= S_DELAY;
            cnt         <= '0;
            retry       <= '0;
            Index       <= '0;
            Go          <= 1'b0;
            Config_Done <= 1'b0;
            Config_Err  <= 1'b0;
            IIC_data    <= 24'h341E00;
        end else begin
            IIC_data <= word;
            if (ok || fail) begin
                Go  <= 1'b0;
                cnt <= '0;
                if (ok && Index == 4'd10) begin
                    state       <= S_DONE;
                    Config_Done <= 1'b1;
                end else if (ok) begin
                    state <= S_GAP;
                    Index <= Index + 4'd1;
                    retry <= '0;
                end else if (retry == RW'(MAX_RETRY)) begin
                    state      <= S_ERROR;
                    Config_Err <= 1'b1;
                end else begin
                    state <= S_GAP;
                    retry <= retry + 1'b1;
                end
            end else begin
                case (state)
                    S_DELAY: begin
                        if (cnt == CW'(PD - 1)) begin
                            state <= S_GAP;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    // Wait for the controller to drop End before letting it run again.
                    S_GAP: begin
                        if (cnt >= CW'(GC - 1) && !Iic_End) begin
                            state <= S_RUN;
                            cnt   <= '0;
                            Go    <= 1'b1;
                        end else if (cnt < CW'(GC - 1)) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (Iic_End) state <= S_CHECK;
                        else cnt <= cnt + 1'b1;
                    end
                    S_DONE, S_ERROR: begin
                        if (Start) begin
                            state       <= S_DELAY;
                            cnt         <= '0;
                            retry       <= '0;
                            Index       <= '0;
                            Config_Done <= 1'b0;
                            Config_Err  <= 1'b0;
                        end
                    end
                    default: state <= S_DELAY;
                endcase
            end
        end
    end
endmodule
